// File: rtl/ctrl_encode_def.sv
// Shared control encodings for the pipeline: ALU opcodes and the ID/EX stage
// register layout used by the execute-side logic.
package ctrl_encode_def;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'h0,
        ALU_ADD  = 4'h1,
        ALU_SUB  = 4'h2,
        ALU_AND  = 4'h3,
        ALU_OR   = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_NOR  = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9,
        ALU_SLT  = 4'hA,
        ALU_SLTU = 4'hB,
        ALU_LUI  = 4'hC
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rdata_a;
        logic [31:0] rdata_b;
        logic [31:0] imm;
        logic        alusrc;
        alu_op_e     aluop;
        logic [4:0]  shamt;
        logic [4:0]  wreg;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
    } id_ex_t;

    // Bubble: no architectural side effects; data fields zeroed for determinism.
    function automatic id_ex_t id_ex_bubble();
        id_ex_t b;
        b       = '0;
        b.aluop = ALU_NOP;
        return b;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding mux for one source register: EX/MEM beats MEM/WB beats
// the register-file value captured in the stage register.
module fwd_unit (
    input  logic [4:0]  src_reg,
    input  logic [31:0] reg_data,
    input  logic        exm_regwrite,
    input  logic [4:0]  exm_wreg,
    input  logic [31:0] exm_result,
    input  logic        mw_regwrite,
    input  logic [4:0]  mw_wreg,
    input  logic [31:0] mw_wdata,
    output logic [31:0] fwd_data
);

    logic exm_hit;
    logic mw_hit;

    // $0 is hardwired to zero, so a write "to" it must never be forwarded.
    assign exm_hit = exm_regwrite && (exm_wreg != 5'd0) && (exm_wreg == src_reg);
    assign mw_hit  = mw_regwrite  && (mw_wreg  != 5'd0) && (mw_wreg  == src_reg);

    always_comb begin
        // NOTE: default first so every path assigns fwd_data and no latch is inferred.
        fwd_data = reg_data;
        if (exm_hit) begin
            fwd_data = exm_result;
        end else if (mw_hit) begin
            fwd_data = mw_wdata;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX-stage operand
// forwarding from the EX/MEM and MEM/WB stages.
module id_ex_stage
    import ctrl_encode_def::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [31:0] id_rdata_a,
    input  logic [31:0] id_rdata_b,
    input  logic [31:0] id_imm,
    input  logic        id_alusrc,
    input  logic [3:0]  id_aluop,
    input  logic [4:0]  id_shamt,
    input  logic [4:0]  id_wreg,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        flush,
    input  logic        hold,
    input  logic        exm_regwrite,
    input  logic [4:0]  exm_wreg,
    input  logic [31:0] exm_result,
    input  logic        mw_regwrite,
    input  logic [4:0]  mw_wreg,
    input  logic [31:0] mw_wdata,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [4:0]  alu_shamt,
    output logic [31:0] ex_store_data,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic [4:0]  ex_wreg,
    output logic        stall
);

    id_ex_t      stage_q;
    id_ex_t      stage_d;
    id_ex_t      id_in;
    logic        load_use;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    always_comb begin
        id_in          = '0;
        id_in.valid    = id_valid;
        id_in.rs       = id_rs;
        id_in.rt       = id_rt;
        id_in.rdata_a  = id_rdata_a;
        id_in.rdata_b  = id_rdata_b;
        id_in.imm      = id_imm;
        id_in.alusrc   = id_alusrc;
        id_in.aluop    = alu_op_e'(id_aluop);
        id_in.shamt    = id_shamt;
        id_in.wreg     = id_wreg;
        id_in.regwrite = id_regwrite;
        id_in.memread  = id_memread;
        id_in.memwrite = id_memwrite;
    end

    // A load in EX cannot supply its data until MEM, so a dependent ID op waits one cycle.
    assign load_use = stage_q.valid && stage_q.memread && (stage_q.wreg != 5'd0)
                   && ((stage_q.wreg == id_rs) || (id_uses_rt && (stage_q.wreg == id_rt)));
    assign stall    = load_use && id_valid && !flush && !hold;

    always_comb begin
        stage_d = stage_q;
        if (hold) begin
            stage_d = stage_q;
        end else if (flush || stall) begin
            stage_d = id_ex_bubble();
        end else begin
            stage_d = id_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments for flops so every register samples pre-edge values.
            stage_q <= id_ex_bubble();
        end else begin
            stage_q <= stage_d;
        end
    end

    fwd_unit u_fwd_rs (
        .src_reg      (stage_q.rs),
        .reg_data     (stage_q.rdata_a),
        .exm_regwrite (exm_regwrite),
        .exm_wreg     (exm_wreg),
        .exm_result   (exm_result),
        .mw_regwrite  (mw_regwrite),
        .mw_wreg      (mw_wreg),
        .mw_wdata     (mw_wdata),
        .fwd_data     (fwd_rs)
    );

    fwd_unit u_fwd_rt (
        .src_reg      (stage_q.rt),
        .reg_data     (stage_q.rdata_b),
        .exm_regwrite (exm_regwrite),
        .exm_wreg     (exm_wreg),
        .exm_result   (exm_result),
        .mw_regwrite  (mw_regwrite),
        .mw_wreg      (mw_wreg),
        .mw_wdata     (mw_wdata),
        .fwd_data     (fwd_rt)
    );

    assign alu_a         = fwd_rs;
    assign alu_b         = stage_q.alusrc ? stage_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_op        = stage_q.aluop;
    assign alu_shamt     = stage_q.shamt;
    assign ex_valid      = stage_q.valid;
    assign ex_regwrite   = stage_q.regwrite;
    assign ex_memread    = stage_q.memread;
    assign ex_memwrite   = stage_q.memwrite;
    assign ex_wreg       = stage_q.wreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: reset, forwarding priority, $0
// handling, load-use stall, flush/hold interaction and async reset.
module tb_id_ex_stage;
    import ctrl_encode_def::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rt, id_alusrc;
    logic [4:0]  id_rs, id_rt, id_shamt, id_wreg;
    logic [31:0] id_rdata_a, id_rdata_b, id_imm;
    logic [3:0]  id_aluop;
    logic        id_regwrite, id_memread, id_memwrite;
    logic        flush, hold;
    logic        exm_regwrite, mw_regwrite;
    logic [4:0]  exm_wreg, mw_wreg;
    logic [31:0] exm_result, mw_wdata;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt, ex_wreg;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, stall;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_rdata_a(id_rdata_a), .id_rdata_b(id_rdata_b), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_shamt(id_shamt),
        .id_wreg(id_wreg), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .flush(flush), .hold(hold),
        .exm_regwrite(exm_regwrite), .exm_wreg(exm_wreg), .exm_result(exm_result),
        .mw_regwrite(mw_regwrite), .mw_wreg(mw_wreg), .mw_wdata(mw_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_wreg(ex_wreg),
        .stall(stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs settle before the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urt, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic asrc, input logic [3:0] op,
                          input logic [4:0] wreg, input logic rw, input logic mr,
                          input logic mw);
        id_valid = v;      id_rs = rs;       id_rt = rt;      id_uses_rt = urt;
        id_rdata_a = a;    id_rdata_b = b;   id_imm = imm;    id_alusrc = asrc;
        id_aluop = op;     id_wreg = wreg;   id_regwrite = rw;
        id_memread = mr;   id_memwrite = mw; id_shamt = 5'd0;
    endtask

    task automatic clear_fwd();
        exm_regwrite = 1'b0; exm_wreg = 5'd0; exm_result = '0;
        mw_regwrite  = 1'b0; mw_wreg  = 5'd0; mw_wdata   = '0;
    endtask

    // lw $8, 0($2)
    task automatic set_lw8();
        set_id(1, 5'd2, 5'd8, 0, 32'h100, 32'h0, 32'h0, 1, ALU_ADD, 5'd8, 1, 1, 0);
    endtask

    // add $10, $9, $8 -- depends on $8 through rt
    task automatic set_dep();
        set_id(1, 5'd9, 5'd8, 1, 32'h9, 32'h8, 32'h0, 0, ALU_ADD, 5'd10, 1, 0, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; hold = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        clear_fwd();
        #12;
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_aluop", {28'd0, alu_op}, {28'd0, ALU_NOP});
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_store", ex_store_data, 32'd0);

        // First instruction after reset loads on the next edge.
        rst = 1'b0;
        set_id(1, 5'd5, 5'd6, 1, 32'hA, 32'hB, 32'h0, 0, ALU_SUB, 5'd3, 1, 0, 0);
        id_shamt = 5'd4;
        tick();
        check("ld_valid", {31'd0, ex_valid}, 32'd1);
        check("ld_alu_a", alu_a, 32'hA);
        check("ld_alu_b", alu_b, 32'hB);
        check("ld_aluop", {28'd0, alu_op}, {28'd0, ALU_SUB});
        check("ld_shamt", {27'd0, alu_shamt}, 32'd4);
        check("ld_wreg", {27'd0, ex_wreg}, 32'd3);

        // EX/MEM beats MEM/WB on rs=5; MEM/WB takes over when EX/MEM drops.
        exm_regwrite = 1; exm_wreg = 5'd5; exm_result = 32'h11;
        mw_regwrite  = 1; mw_wreg  = 5'd5; mw_wdata   = 32'h22;
        #1 check("fwd_exm", alu_a, 32'h11);
        exm_regwrite = 0;
        #1 check("fwd_mw", alu_a, 32'h22);
        check("fwd_rt_none", alu_b, 32'hB);
        clear_fwd();

        // $0 is never forwarded.
        set_id(1, 5'd0, 5'd0, 1, 32'h1234, 32'h5678, 32'h0, 0, ALU_OR, 5'd4, 1, 0, 0);
        tick();
        exm_regwrite = 1; exm_wreg = 5'd0; exm_result = 32'hFFFF;
        mw_regwrite  = 1; mw_wreg  = 5'd0; mw_wdata   = 32'hEEEE;
        #1 check("r0_alu_a", alu_a, 32'h1234);
        check("r0_store", ex_store_data, 32'h5678);
        clear_fwd();

        // Immediate selects ALU B; store data still carries forwarded rt.
        set_id(1, 5'd1, 5'd7, 1, 32'h1, 32'h5, 32'h10, 1, ALU_ADD, 5'd0, 0, 0, 1);
        tick();
        exm_regwrite = 1; exm_wreg = 5'd7; exm_result = 32'h33;
        mw_regwrite  = 1; mw_wreg  = 5'd7; mw_wdata   = 32'h44;
        #1 check("imm_alu_b", alu_b, 32'h10);
        check("imm_store", ex_store_data, 32'h33);
        exm_regwrite = 0;
        #1 check("imm_store_mw", ex_store_data, 32'h44);
        clear_fwd();

        // Load-use through rt: one stall cycle, one bubble, then the consumer loads.
        set_lw8();
        tick();
        set_dep();
        #1 check("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        check("lu_bubble_op", {28'd0, alu_op}, {28'd0, ALU_NOP});
        check("lu_bubble_rw", {31'd0, ex_regwrite}, 32'd0);
        check("lu_stall_clear", {31'd0, stall}, 32'd0);
        tick();
        check("lu_load_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_load_wreg", {27'd0, ex_wreg}, 32'd10);

        // Same registers but rt not read: no hazard.
        set_lw8();
        tick();
        set_dep();
        id_uses_rt = 0;
        #1 check("nouse_stall", {31'd0, stall}, 32'd0);

        // Flush beats stall: no stall output, bubble loaded.
        set_lw8();
        tick();
        set_dep();
        flush = 1;
        #1 check("fl_stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 0;
        check("fl_valid", {31'd0, ex_valid}, 32'd0);
        check("fl_memread", {31'd0, ex_memread}, 32'd0);

        // Hold freezes contents, suppresses stall, ignores flush; forwarding stays live.
        set_lw8();
        tick();
        set_dep();
        hold = 1;
        #1 check("hd_stall", {31'd0, stall}, 32'd0);
        tick();
        check("hd_valid", {31'd0, ex_valid}, 32'd1);
        check("hd_memread", {31'd0, ex_memread}, 32'd1);
        check("hd_wreg", {27'd0, ex_wreg}, 32'd8);
        flush = 1;
        tick();
        check("hdfl_valid", {31'd0, ex_valid}, 32'd1);
        check("hdfl_alu_a", alu_a, 32'h100);
        exm_regwrite = 1; exm_wreg = 5'd2; exm_result = 32'h2222;
        #1 check("hd_fwd", alu_a, 32'h2222);
        clear_fwd();
        hold = 0; flush = 0;

        // Asynchronous reset mid-operation with a load in EX.
        #1 rst = 1;
        #1 check("arst_valid", {31'd0, ex_valid}, 32'd0);
        check("arst_aluop", {28'd0, alu_op}, {28'd0, ALU_NOP});
        check("arst_stall", {31'd0, stall}, 32'd0);
        check("arst_memread", {31'd0, ex_memread}, 32'd0);
        check("arst_alu_a", alu_a, 32'd0);
        #3 rst = 0;
        set_id(1, 5'd3, 5'd4, 1, 32'h77, 32'h88, 32'h0, 0, ALU_XOR, 5'd9, 1, 0, 0);
        tick();
        check("post_rst_valid", {31'd0, ex_valid}, 32'd1);
        check("post_rst_alu_a", alu_a, 32'h77);
        check("post_rst_op", {28'd0, alu_op}, {28'd0, ALU_XOR});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 id_valid  in  1  decode-stage instruction valid.
REQ-004 id_rs, id_rt  in  5 each  source register numbers.
REQ-005 id_uses_rt  in  1  instruction reads rt.
REQ-006 id_rdata_a, id_rdata_b  in  32 each  register-file read data for rs and rt.
REQ-007 id_imm  in  32  extended immediate; id_alusrc in 1 selects imm as ALU B.
REQ-008 id_aluop  in  4  ALU opcode; id_shamt in 5 shift amount.
REQ-009 id_wreg  in  5  destination; id_regwrite, id_memread, id_memwrite in 1 each.
REQ-010 flush  in  1  kill the decode-stage instruction (branch/jump redirect).
REQ-011 hold  in  1  downstream stall; freeze this stage.
REQ-012 exm_regwrite in 1, exm_wreg in 5, exm_result in 32  EX/MEM forwarding source.
REQ-013 mw_regwrite in 1, mw_wreg in 5, mw_wdata in 32  MEM/WB forwarding source.
REQ-014 alu_a, alu_b  out  32 each  forwarded ALU operands.
REQ-015 alu_op out 4, alu_shamt out 5  registered ALU controls.
REQ-016 ex_store_data  out  32  forwarded rt value for stores.
REQ-017 ex_valid, ex_regwrite, ex_memread, ex_memwrite out 1 each; ex_wreg out 5.
REQ-018 stall  out  1  load-use stall request to IF/ID.

Function
REQ-019 Stage register SHALL capture valid, rs, rt, rdata_a/b, imm, alusrc, aluop, shamt, wreg, regwrite, memread, memwrite.
REQ-020 Update priority per edge SHALL be: hold (keep all contents) > flush (bubble) > stall (bubble) > load from ID.
REQ-021 Bubble SHALL set valid=0, aluop=ALU_NOP, regwrite=memread=memwrite=0, wreg=0; data fields don't-care.
REQ-022 stall SHALL = ex_valid & ex_memread & ex_wreg!=0 & id_valid & !flush & !hold & (ex_wreg==id_rs | (id_uses_rt & ex_wreg==id_rt)).
REQ-023 Forwarded rs SHALL be exm_result if exm_regwrite & exm_wreg!=0 & exm_wreg==rs; else mw_wdata if mw_regwrite & mw_wreg!=0 & mw_wreg==rs; else registered rdata_a.
REQ-024 Forwarded rt SHALL use identical rule with rt and rdata_b; EX/MEM always beats MEM/WB.
REQ-025 Register 0 SHALL never be forwarded.
REQ-026 alu_a = fwd_rs; alu_b = alusrc ? imm : fwd_rt; ex_store_data = fwd_rt (independent of alusrc).
REQ-027 Forwarding SHALL be combinational from current stage register and forwarding inputs, re-evaluated every cycle including while held.
REQ-028 Latency ID->EX SHALL be one cycle; stall inserts exactly one bubble per load-use pair.
REQ-029 Flush and stall in same cycle: flush wins, stall output 0.
REQ-030 Flush while hold asserted SHALL be ignored; upstream keeps flush asserted until hold drops.

Reset
REQ-031 rst SHALL immediately force the bubble state (REQ-021) and all other fields to 0, independent of clk.
REQ-032 During reset stall SHALL be 0, alu_a = alu_b = ex_store_data = 0 absent forwarding hits.
REQ-033 Reset deassertion mid-stream SHALL load the first ID instruction on the next edge.

Structure
REQ-034 ALU opcode encodings (ALU_NOP etc.) SHALL come from the shared ctrl_encode_def definitions; no local copies.
REQ-035 Forwarding select SHALL be a sub-module fwd_unit, instantiated twice (rs, rt).

Verification
REQ-036 Reset mid-operation with ex_valid=1 -> outputs bubble immediately, alu_op=ALU_NOP, stall=0.
REQ-037 rs=5, exm_wreg=5 exm_result=0x11, mw_wreg=5 mw_wdata=0x22 -> alu_a=0x11; drop exm_regwrite -> alu_a=0x22.
REQ-038 rs=0 with exm_wreg=0 exm_regwrite=1 exm_result=0xFFFF -> alu_a = registered rdata_a.
REQ-039 EX holds lw to $8, ID rt=8 id_uses_rt=1 -> stall=1 one cycle, next cycle ex_valid=0; following cycle ID instruction loads.
REQ-040 Same as REQ-039 with flush=1 -> stall=0, bubble loaded; with hold=1 -> contents unchanged, stall=0.
REQ-041 alusrc=1, imm=0x10, rt forwarded 0x33 -> alu_b=0x10, ex_store_data=0x33.
